blockram_fifo_controller: RTL and testbench



---
 rtl/blockram_fifo_controller.sv | 155 +++++++++++++++
 tb/tb_blockram_fifo_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockram_fifo_controller.sv
// FIFO controller driving an external dual-port blockram as its storage array.
// A two-entry output buffer hides the one-cycle blockram read latency.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module blockram_fifo_controller #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  flush_in,
    input  logic                                  in_valid_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] in_data_in,
    output logic                                  in_ready_out,
    output logic                                  out_valid_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] out_data_out,
    input  logic                                  out_ready_in,
    output logic [SET_PTR_WIDTH_IN_BITS+1:0]      occupancy_out,
    output logic                                  error_out,
    output logic                                  bram_write_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             bram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      bram_write_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] bram_write_data_out,
    output logic                                  bram_read_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      bram_read_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] bram_read_data_in,
    input  logic                                  bram_read_valid_in
);

    localparam int PW = SET_PTR_WIDTH_IN_BITS;
    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(NUM_SET);
    localparam logic [PW:0] PTR_ONE    = (PW+1)'(1);
    localparam logic [PW:0] PTR_ZERO   = (PW+1)'(0);

    logic [PW:0]  wr_ptr_r, rd_ptr_r, bram_count_s;
    logic         pending_r, error_r;
    logic [1:0]   buf_cnt_r, buf_cnt_next_s;
    logic [W-1:0] buf0_r, buf1_r, buf0_next_s, buf1_next_s;
    logic         full_s, push_s, pop_s, ret_s, rd_issue_s;
    logic [2:0]   held_s;

    // Handshakes and prefetch decision; a pop in this cycle frees a slot for the next return.
    always_comb begin
        bram_count_s  = wr_ptr_r - rd_ptr_r;
        full_s        = (bram_count_s == FULL_COUNT);
        in_ready_out  = reset_in && !full_s;
        out_valid_out = (buf_cnt_r != 2'd0);
        push_s        = in_valid_in && in_ready_out && !flush_in;
        pop_s         = out_valid_out && out_ready_in && !flush_in;
        ret_s         = pending_r && !flush_in;
        held_s        = {1'b0, buf_cnt_r} + {2'b00, pending_r} - {2'b00, pop_s};
        rd_issue_s    = !flush_in && (bram_count_s != PTR_ZERO) && (held_s < 3'd2);
    end

    // Blockram port drive, zeroed whenever no access is made.
    always_comb begin
        if (push_s) begin
            bram_write_access_en_out = 1'b1;
            bram_write_en_out        = {WRITE_MASK_LEN{1'b1}};
            bram_write_set_addr_out  = wr_ptr_r[PW-1:0];
            bram_write_data_out      = in_data_in;
        end else begin
            bram_write_access_en_out = 1'b0;
            bram_write_en_out        = {WRITE_MASK_LEN{1'b0}};
            bram_write_set_addr_out  = {PW{1'b0}};
            bram_write_data_out      = {W{1'b0}};
        end
        if (rd_issue_s) begin
            bram_read_access_en_out = 1'b1;
            bram_read_set_addr_out  = rd_ptr_r[PW-1:0];
        end else begin
            bram_read_access_en_out = 1'b0;
            bram_read_set_addr_out  = {PW{1'b0}};
        end
    end

    // Output buffer next state: entry 0 is always the head.
    always_comb begin
        buf0_next_s    = buf0_r;
        buf1_next_s    = buf1_r;
        buf_cnt_next_s = buf_cnt_r;
        case ({ret_s, pop_s})
            2'b10: begin
                if (buf_cnt_r == 2'd0) begin
                    buf0_next_s = bram_read_data_in;
                end else begin
                    buf1_next_s = bram_read_data_in;
                end
                buf_cnt_next_s = buf_cnt_r + 2'd1;
            end
            2'b01: begin
                buf0_next_s    = buf1_r;
                buf_cnt_next_s = buf_cnt_r - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_r == 2'd1) begin
                    buf0_next_s = bram_read_data_in;
                end else begin
                    buf0_next_s = buf1_r;
                    buf1_next_s = bram_read_data_in;
                end
            end
            default: begin
                buf_cnt_next_s = buf_cnt_r;
            end
        endcase
    end

    // Pointer, pending-read and buffer state; flush clears contents synchronously.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            pending_r <= 1'b0;
            buf_cnt_r <= 2'd0;
            buf0_r    <= {W{1'b0}};
            buf1_r    <= {W{1'b0}};
        end else if (flush_in) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            pending_r <= 1'b0;
            buf_cnt_r <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            pending_r <= rd_issue_s;
            buf_cnt_r <= buf_cnt_next_s;
            buf0_r    <= buf0_next_s;
            buf1_r    <= buf1_next_s;
        end
    end

    // Sticky error: a read came back without the blockram flagging it valid.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            error_r <= 1'b0;
        end else if (ret_s && !bram_read_valid_in) begin
            error_r <= 1'b1;
        end
    end

    assign out_data_out  = buf0_r;
    assign error_out     = error_r;
    assign occupancy_out = {1'b0, bram_count_s} + (PW+2)'(pending_r) + (PW+2)'(buf_cnt_r);

endmodule

// File: tb/tb_blockram_fifo_controller.sv
// Scoreboard bench for blockram_fifo_controller with a behavioural blockram model.
module tb_blockram_fifo_controller;
    localparam int W  = 64;
    localparam int NS = 64;
    localparam int PW = 6;
    localparam int ML = 8;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, in_ready, out_valid, out_ready, err, drop_valid;
    logic [W-1:0]  in_data, out_data, bram_wdata, bram_rdata;
    logic [PW+1:0] occ;
    logic          bram_wen, bram_ren, bram_rvalid;
    logic [ML-1:0] bram_we;
    logic [PW-1:0] bram_waddr, bram_raddr;
    logic [W-1:0]  mem [NS];
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  exp_w;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    blockram_fifo_controller #(.SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_SET(NS)) dut (
        .clk_in(clk), .reset_in(rst_n), .flush_in(flush),
        .in_valid_in(in_valid), .in_data_in(in_data), .in_ready_out(in_ready),
        .out_valid_out(out_valid), .out_data_out(out_data), .out_ready_in(out_ready),
        .occupancy_out(occ), .error_out(err),
        .bram_write_access_en_out(bram_wen), .bram_write_en_out(bram_we),
        .bram_write_set_addr_out(bram_waddr), .bram_write_data_out(bram_wdata),
        .bram_read_access_en_out(bram_ren), .bram_read_set_addr_out(bram_raddr),
        .bram_read_data_in(bram_rdata), .bram_read_valid_in(bram_rvalid)
    );

    // Blockram model: byte-masked write, one-cycle registered read.
    always @(posedge clk) begin
        for (int b = 0; b < ML; b++) begin
            if (bram_wen && bram_we[b]) mem[bram_waddr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
        end
        bram_rvalid <= bram_ren && !drop_valid;
        if (bram_ren) bram_rdata <= mem[bram_raddr];
    end

    // Scoreboard: accepted words are queued, every output word is popped and compared.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: actual %0h, required no output", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin
                        n_err++;
                        $display("FAIL sb_data: actual %0h, required %0h", out_data, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: actual not accepted, required accepted (data %0h)", d);
        end
    endtask

    initial begin
        int pushes, pops, first_k, gaps;
        bit prod_done;
        bit got;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; drop_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_occupancy", W'(occ), W'(0));
        check("rst_error", W'(err), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_bram_wr", W'(bram_wen), W'(0));
        check("rst_bram_rd", W'(bram_ren), W'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic ordering
        out_ready = 1'b1; in_valid = 1'b1; in_data = {32{2'b01}};
        #1;
        check("wr_access", W'(bram_wen), W'(1));
        check("wr_mask", W'(bram_we), W'(8'hFF));
        check("wr_addr0", W'(bram_waddr), W'(0));
        check("wr_data", bram_wdata, {32{2'b01}});
        tick();
        in_data = {32{2'b10}};
        #1;
        check("wr_addr1", W'(bram_waddr), W'(1));
        tick();
        in_valid = 1'b0;
        check("latency_e1", W'(out_valid), W'(0));
        tick();
        check("latency_e2", W'(out_valid), W'(1));
        check("first_word", out_data, {32{2'b01}});
        repeat (6) tick();
        check("basic_occ", W'(occ), W'(0));
        check("basic_err", W'(err), W'(0));
        check("basic_drained", W'(exp_q.size()), W'(0));

        // Fill
        out_ready = 1'b0;
        for (int i = 0; i < NS + 2; i++) push_word(W'(i));
        check("fill_in_ready", W'(in_ready), W'(0));
        check("fill_occ", W'(occ), W'(66));
        in_valid = 1'b1; in_data = W'(64'hDEAD);
        repeat (3) tick();
        in_valid = 1'b0;
        check("fill_occ_hold", W'(occ), W'(66));

        // Drain
        out_ready = 1'b1;
        repeat (80) tick();
        check("drain_occ", W'(occ), W'(0));
        check("drain_empty", W'(exp_q.size()), W'(0));

        // Wrap with random stalls
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_word(64'hC0DE_0000_0000_0000 + W'(i));
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        repeat (20) tick();
        check("wrap_occ", W'(occ), W'(0));
        check("wrap_empty", W'(exp_q.size()), W'(0));

        // Sustained throughput
        out_ready = 1'b1; in_valid = 1'b1; in_data = W'(64'h100);
        pushes = 0; pops = 0; first_k = -1; gaps = 0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first_k < 0) first_k = k;
                pops++;
            end else if (first_k >= 0 && pops < 100) begin
                gaps++;
            end
            if (in_valid && in_ready) pushes++;
            tick();
            if (pushes == 100) in_valid = 1'b0;
            else in_data = W'(64'h100) + W'(pushes);
        end
        in_valid = 1'b0;
        check("tput_first", W'(first_k), W'(3));
        check("tput_pops", W'(pops), W'(100));
        check("tput_gaps", W'(gaps), W'(0));

        // Flush with a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) push_word(W'(64'hF000) + W'(i));
        repeat (3) tick();
        check("pre_flush_occ", W'(occ), W'(11));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush_cycle_occ", W'(occ), W'(10));
        check("flush_no_read", W'(bram_ren), W'(0));
        tick();
        flush = 1'b0;
        check("post_flush_occ", W'(occ), W'(0));
        check("post_flush_valid", W'(out_valid), W'(0));
        repeat (2) tick();
        check("flush_discard", W'(out_valid), W'(0));
        push_word(W'(64'h1234));
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        check("flush_next_data", out_data, W'(64'h1234));
        tick();
        out_ready = 1'b0;

        // Reset mid-operation
        for (int i = 0; i < 5; i++) push_word(W'(64'hA000) + W'(i));
        repeat (3) tick();
        check("pre_rst_occ", W'(occ), W'(5));
        in_valid = 1'b1; rst_n = 1'b0;
        #1;
        check("midrst_valid", W'(out_valid), W'(0));
        check("midrst_occ", W'(occ), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(0));
        check("midrst_bram_wr", W'(bram_wen), W'(0));
        tick();
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
        check("postrst_valid", W'(out_valid), W'(0));
        check("postrst_occ", W'(occ), W'(0));
        check("postrst_in_ready", W'(in_ready), W'(1));

        // Error on invalid return
        drop_valid = 1'b1;
        push_word(W'(64'hE1));
        repeat (3) tick();
        drop_valid = 1'b0;
        check("err_set", W'(err), W'(1));
        check("err_data_kept", out_data, W'(64'hE1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        check("err_sticky", W'(err), W'(1));
        rst_n = 1'b0;
        #1;
        check("err_cleared", W'(err), W'(0));
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
